// File: rtl/rx_tx_pkg.sv
// rx_tx_pkg: shared arbiter state type, timeout default and round-robin helper.
package rx_tx_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} arb_state_t;

    localparam int ARB_TIMEOUT_CYCLES = 4096;

    function automatic int rr_next(int idx, int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rx_ingress_arbiter_if.sv
// rx_ingress_arbiter_if: rx port strobes, memory write stream and status counters.
interface rx_ingress_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_PORTS-1:0]                 port_req_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data_i;
    logic [NUM_PORTS-1:0]                 port_valid_i;
    logic [NUM_PORTS-1:0]                 port_sof_i;
    logic [NUM_PORTS-1:0]                 port_eof_i;
    logic [NUM_PORTS-1:0]                 port_error_i;
    logic [NUM_PORTS-1:0]                 port_grant_o;
    logic                                 mem_ready_i;
    logic [DATA_WIDTH-1:0]                mem_data_o;
    logic                                 mem_valid_o;
    logic                                 mem_sof_o;
    logic                                 mem_eof_o;
    logic                                 mem_error_o;
    logic [$clog2(NUM_PORTS)-1:0]         mem_port_o;
    logic [31:0]                          frame_count_o;
    logic [15:0]                          timeout_count_o;

    modport slave (
        input  port_req_i, port_data_i, port_valid_i, port_sof_i, port_eof_i, port_error_i, mem_ready_i,
        output port_grant_o, mem_data_o, mem_valid_o, mem_sof_o, mem_eof_o, mem_error_o, mem_port_o,
               frame_count_o, timeout_count_o
    );

    modport master (
        output port_req_i, port_data_i, port_valid_i, port_sof_i, port_eof_i, port_error_i, mem_ready_i,
        input  port_grant_o, mem_data_o, mem_valid_o, mem_sof_o, mem_eof_o, mem_error_o, mem_port_o,
               frame_count_o, timeout_count_o
    );

endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first requester at or after the pointer, wrapping around.
module rr_priority_picker #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr_i,
    output logic [NUM_PORTS-1:0]         onehot_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_o,
    output logic                         any_o
);
    localparam int IW = $clog2(NUM_PORTS);

    logic [IW-1:0] j;

    // Scan farthest-first so the nearest requester to the pointer wins.
    always_comb begin
        idx_o = '0;
        j     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            j = IW'((int'(ptr_i) + i) % NUM_PORTS);
            if (req_i[j]) idx_o = j;
        end
    end

    assign any_o    = |req_i;
    assign onehot_o = any_o ? (NUM_PORTS'(1) << idx_o) : '0;

endmodule

// File: rtl/rx_ingress_arbiter.sv
// rx_ingress_arbiter: round-robin frame arbiter from rx MAC ports onto one memory write port,
// with a per-frame ready-cycle timeout that truncates the frame and flushes the rest.
module rx_ingress_arbiter
    import rx_tx_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input logic switch_clk,
    input logic switch_rst,
    rx_ingress_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic [NUM_PORTS-1:0]  owner_oh_q, owner_oh_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, err_q, err_d;
    logic [31:0]           fcnt_q, fcnt_d;
    logic [15:0]           tocnt_q, tocnt_d;

    logic [NUM_PORTS-1:0] pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 own_valid, own_sof, own_eof, own_err, take, eof_take, tout;

    rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req_i    (bus.port_req_i),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign own_valid = bus.port_valid_i[owner_q];
    assign own_sof   = bus.port_sof_i[owner_q];
    assign own_eof   = bus.port_eof_i[owner_q];
    assign own_err   = bus.port_error_i[owner_q];
    // A byte is consumed whenever the owner is valid while its grant is high.
    assign take      = own_valid & ((state_q == FLUSH) | bus.mem_ready_i);
    assign eof_take  = take & own_eof;
    assign tout      = (state_q == BUSY) & bus.mem_ready_i & (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) & ~eof_take;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        tcnt_d     = tcnt_q;
        data_d     = (state_q == BUSY) ? bus.port_data_i[owner_q] : '0;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;
        fcnt_d     = fcnt_q;
        tocnt_d    = tocnt_q;
        case (state_q)
            IDLE: if (pick_any) begin
                owner_d    = pick_idx;
                owner_oh_d = pick_oh;
                tcnt_d     = '0;
                state_d    = BUSY;
            end
            BUSY: begin
                valid_d = take & ~tout;
                sof_d   = take & own_sof & ~tout;
                eof_d   = eof_take | tout;
                err_d   = (take & own_err) | tout;
                tcnt_d  = tcnt_q + TW'(bus.mem_ready_i);
                if (eof_take) begin
                    fcnt_d   = fcnt_q + 32'd1;
                    rr_ptr_d = IW'(rr_next(int'(owner_q), NUM_PORTS));
                    state_d  = IDLE;
                end else if (tout) begin
                    tocnt_d = tocnt_q + 16'd1;
                    state_d = FLUSH;
                end
            end
            FLUSH: if (eof_take) begin
                rr_ptr_d = IW'(rr_next(int'(owner_q), NUM_PORTS));
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge switch_clk or posedge switch_rst) begin
        if (switch_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            owner_oh_q <= '0;
            tcnt_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
            tocnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            tcnt_q     <= tcnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            fcnt_q     <= fcnt_d;
            tocnt_q    <= tocnt_d;
        end
    end

    assign bus.port_grant_o    = (state_q == BUSY)  ? (owner_oh_q & {NUM_PORTS{bus.mem_ready_i}}) :
                                 (state_q == FLUSH) ? owner_oh_q : '0;
    assign bus.mem_data_o      = data_q;
    assign bus.mem_valid_o     = valid_q;
    assign bus.mem_sof_o       = sof_q;
    assign bus.mem_eof_o       = eof_q;
    assign bus.mem_error_o     = err_q;
    assign bus.mem_port_o      = owner_q;
    assign bus.frame_count_o   = fcnt_q;
    assign bus.timeout_count_o = tocnt_q;

endmodule

// File: tb/tb_rx_ingress_arbiter.sv
// tb_rx_ingress_arbiter: frame sources feed the arbiter; a scoreboard holds the expected
// memory stream derived from round-robin order and frame-length/timeout arithmetic.
module tb_rx_ingress_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int TO = 100;

    typedef struct {
        logic [DW-1:0] data;
        bit            sof;
        bit            eof;
        bit            err;
        bit            to;
        int            port;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_ingress_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    rx_ingress_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .switch_clk (clk),
        .switch_rst (rst),
        .bus        (bus)
    );

    logic [DW-1:0] src_b[NP][$];
    int            src_len[NP][$];
    bit            src_err[NP][$];
    int            src_pos[NP];
    exp_t          exp_q[$];
    exp_t          mon_e;
    int            m_ptr = 0, m_frames = 0, m_touts = 0;
    int            compared = 0, mismatched = 0;
    int            ready_pct = 100, lo_from = 0, lo_to = 0, pc = 0;
    bit            lo_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    task automatic add_frame(input int p, input int len, input bit err);
        for (int i = 0; i < len; i++) src_b[p].push_back(DW'($urandom));
        src_len[p].push_back(len);
        src_err[p].push_back(err);
    endtask

    function automatic bit srcs_empty();
        for (int p = 0; p < NP; p++) if (src_len[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Expected stream: round-robin over pending frames; frames longer than TO are cut after TO-1 bytes.
    task automatic plan();
        int   nf[NP];
        int   off[NP];
        int   left, p, len;
        exp_t e;
        left = 0;
        for (int q = 0; q < NP; q++) begin
            nf[q] = 0;
            off[q] = 0;
            left += src_len[q].size();
        end
        while (left > 0) begin
            p = -1;
            for (int k = 0; k < NP; k++)
                if (p < 0 && nf[(m_ptr + k) % NP] < src_len[(m_ptr + k) % NP].size()) p = (m_ptr + k) % NP;
            len = src_len[p][nf[p]];
            e.to = 1'b0;
            e.port = p;
            for (int i = 0; i < ((len <= TO) ? len : TO - 1); i++) begin
                e.data = src_b[p][off[p] + i];
                e.sof  = (i == 0);
                e.eof  = (len <= TO) && (i == len - 1);
                e.err  = e.eof && src_err[p][nf[p]];
                exp_q.push_back(e);
            end
            if (len <= TO) m_frames++;
            else begin
                e.data = '0;
                e.sof  = 1'b0;
                e.eof  = 1'b1;
                e.err  = 1'b1;
                e.to   = 1'b1;
                exp_q.push_back(e);
                m_touts++;
            end
            off[p] += len;
            nf[p]++;
            left--;
            m_ptr = (p + 1) % NP;
        end
    endtask

    task automatic drive();
        bit last;
        for (int p = 0; p < NP; p++) begin
            if (src_len[p].size() > 0) begin
                last = (src_pos[p] == src_len[p][0] - 1);
                bus.port_req_i[p]   = 1'b1;
                bus.port_valid_i[p] = 1'b1;
                bus.port_data_i[p]  = src_b[p][0];
                bus.port_sof_i[p]   = (src_pos[p] == 0);
                bus.port_eof_i[p]   = last;
                bus.port_error_i[p] = last && src_err[p][0];
            end else begin
                bus.port_req_i[p]   = 1'b0;
                bus.port_valid_i[p] = 1'b0;
                bus.port_data_i[p]  = '0;
                bus.port_sof_i[p]   = 1'b0;
                bus.port_eof_i[p]   = 1'b0;
                bus.port_error_i[p] = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [NP-1:0] g;
        @(negedge clk);
        g = bus.port_grant_o;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (g[p] && src_len[p].size() > 0) begin
                void'(src_b[p].pop_front());
                src_pos[p]++;
                if (src_pos[p] == src_len[p][0]) begin
                    void'(src_len[p].pop_front());
                    void'(src_err[p].pop_front());
                    src_pos[p] = 0;
                end
            end
        end
        pc++;
        bus.mem_ready_i = (pc >= lo_from && pc < lo_to) ? 1'b0 : ($urandom_range(99) < ready_pct);
        drive();
    endtask

    task automatic run_phase(input string name);
        int n;
        plan();
        drive();
        pc = 0;
        n = 0;
        while (!(srcs_empty() && exp_q.size() == 0)) begin
            step();
            n++;
            if (n > 6000) begin
                compared++;
                mismatched++;
                $display("FAIL %s: phase stalled, %0d entries still expected", name, exp_q.size());
                finish_all();
            end
        end
        chk({name, "_frame_count"}, 64'(bus.frame_count_o), 64'(m_frames));
        chk({name, "_timeout_count"}, 64'(bus.timeout_count_o), 64'(m_touts));
    endtask

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            src_b[p].delete();
            src_len[p].delete();
            src_err[p].delete();
            src_pos[p] = 0;
        end
        exp_q.delete();
        m_ptr = 0;
        m_frames = 0;
        m_touts = 0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_grant"}, 64'(bus.port_grant_o), 64'd0);
        chk({name, "_valid"}, 64'(bus.mem_valid_o), 64'd0);
        chk({name, "_sof"}, 64'(bus.mem_sof_o), 64'd0);
        chk({name, "_eof"}, 64'(bus.mem_eof_o), 64'd0);
        chk({name, "_error"}, 64'(bus.mem_error_o), 64'd0);
        chk({name, "_port"}, 64'(bus.mem_port_o), 64'd0);
        chk({name, "_frame_count"}, 64'(bus.frame_count_o), 64'd0);
        chk({name, "_timeout_count"}, 64'(bus.timeout_count_o), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("grant_at_most_one", 64'($countones(bus.port_grant_o) <= 1), 64'd1);
            if (lo_chk && !bus.mem_ready_i) chk("grant_low_when_not_ready", 64'(bus.port_grant_o), 64'd0);
            if (bus.mem_valid_o || bus.mem_eof_o) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: valid=%0b eof=%0b port=%0d, want nothing", bus.mem_valid_o, bus.mem_eof_o, bus.mem_port_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mem_valid", 64'(bus.mem_valid_o), 64'(!mon_e.to));
                    chk("mem_sof", 64'(bus.mem_sof_o), 64'(mon_e.sof));
                    chk("mem_eof", 64'(bus.mem_eof_o), 64'(mon_e.eof));
                    chk("mem_error", 64'(bus.mem_error_o), 64'(mon_e.err));
                    chk("mem_port", 64'(bus.mem_port_o), 64'(mon_e.port));
                    if (!mon_e.to) chk("mem_data", 64'(bus.mem_data_o), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        for (int p = 0; p < NP; p++) src_pos[p] = 0;
        bus.mem_ready_i = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;

        add_frame(0, 5, 1'b0);
        add_frame(2, 7, 1'b1);
        run_phase("two_requesters");

        add_frame(1, 64, 1'b0);
        lo_from = 20;
        lo_to = 30;
        lo_chk = 1'b1;
        run_phase("ready_stall");
        lo_chk = 1'b0;
        lo_from = 0;
        lo_to = 0;

        add_frame(0, 130, 1'b0);
        run_phase("timeout");

        add_frame(2, TO, 1'b0);
        run_phase("eof_at_timeout");

        for (int p = 0; p < NP; p++) begin
            add_frame(p, 3 + p, 1'b0);
            add_frame(p, 4, p[0]);
        end
        run_phase("all_ports");

        ready_pct = 70;
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < NP; p++)
                for (int f = 0; f < int'($urandom_range(3)); f++)
                    add_frame(p, ($urandom_range(9) == 0) ? int'($urandom_range(125, 95)) : int'($urandom_range(24, 1)),
                              $urandom_range(3) == 0);
            run_phase("random");
        end

        ready_pct = 100;
        add_frame(3, 50, 1'b0);
        plan();
        drive();
        repeat (20) step();
        rst = 1'b1;
        #1;
        chk_quiet("mid_frame_reset");
        clear_all();
        drive();
        repeat (2) step();
        rst = 1'b0;
        add_frame(3, 6, 1'b0);
        add_frame(1, 6, 1'b0);
        run_phase("after_reset");

        finish_all();
    end

endmodule
